// File: rtl/ex_fwd_ctrl.sv
// EX-stage operand forwarding and load-use hazard controller.
// Tracks in-flight destinations and registers the A/B mux selects for the instruction entering EX.
module ex_fwd_ctrl #(
    parameter int REG_W    = 5,
    parameter int ZERO_REG = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             id_use_imm,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             id_valid,
    input  logic             flush,
    output logic             stall,
    output logic [2:0]       ex_sel_a,
    output logic [2:0]       ex_sel_b,
    output logic             ex_valid
);

    localparam logic [REG_W-1:0] ZERO_R = REG_W'(ZERO_REG);

    localparam logic [2:0] SEL_RF  = 3'b000;
    localparam logic [2:0] SEL_EXM = 3'b001;
    localparam logic [2:0] SEL_MWB = 3'b010;
    localparam logic [2:0] SEL_RET = 3'b011;
    localparam logic [2:0] SEL_IMM = 3'b100;

    logic             ex_valid_q,  ex_valid_d;
    logic [REG_W-1:0] ex_rd_q,     ex_rd_d;
    logic             ex_wr_q,     ex_wr_d;
    logic             ex_ld_q,     ex_ld_d;
    logic             mem_valid_q, mem_valid_d;
    logic [REG_W-1:0] mem_rd_q,    mem_rd_d;
    logic             mem_wr_q,    mem_wr_d;
    logic             wb_valid_q,  wb_valid_d;
    logic [REG_W-1:0] wb_rd_q,     wb_rd_d;
    logic             wb_wr_q,     wb_wr_d;
    logic [2:0]       sel_a_q,     sel_a_d;
    logic [2:0]       sel_b_q,     sel_b_d;
    logic             hazard_s;

    function automatic logic produces(input logic vld, input logic wr,
                                      input logic [REG_W-1:0] rd,
                                      input logic [REG_W-1:0] r);
        return vld && wr && (rd == r) && (r != ZERO_R);
    endfunction

    // Youngest producer wins: the stage now in EX will sit in MEM when the consumer reaches EX.
    function automatic logic [2:0] fwd_sel(input logic [REG_W-1:0] r,
                                           input logic ev, input logic ew, input logic [REG_W-1:0] erd,
                                           input logic mv, input logic mw, input logic [REG_W-1:0] mrd,
                                           input logic wv, input logic ww, input logic [REG_W-1:0] wrd);
        logic [2:0] sel;
        if (produces(ev, ew, erd, r)) begin
            sel = SEL_EXM;
        end else if (produces(mv, mw, mrd, r)) begin
            sel = SEL_MWB;
        end else if (produces(wv, ww, wrd, r)) begin
            sel = SEL_RET;
        end else begin
            sel = SEL_RF;
        end
        return sel;
    endfunction

    // Hazard detection, stage shift and select computation.
    always_comb begin
        hazard_s = id_valid && ex_valid_q && ex_ld_q && ex_wr_q && (ex_rd_q != ZERO_R) &&
                   (((ex_rd_q == id_rs) && id_use_rs) ||
                    ((ex_rd_q == id_rt) && id_use_rt && !id_use_imm));
        stall = hazard_s && !flush;

        mem_valid_d = ex_valid_q;
        mem_rd_d    = ex_rd_q;
        mem_wr_d    = ex_wr_q;
        wb_valid_d  = mem_valid_q;
        wb_rd_d     = mem_rd_q;
        wb_wr_d     = mem_wr_q;

        ex_valid_d = 1'b0;
        ex_rd_d    = id_rd;
        ex_wr_d    = id_reg_write;
        ex_ld_d    = id_mem_read;
        sel_a_d    = SEL_RF;
        sel_b_d    = SEL_RF;

        if (stall || flush) begin
            ex_valid_d = 1'b0;
            ex_wr_d    = 1'b0;
            ex_ld_d    = 1'b0;
        end else begin
            ex_valid_d = id_valid;
            if (id_use_rs) begin
                sel_a_d = fwd_sel(id_rs, ex_valid_q, ex_wr_q, ex_rd_q,
                                  mem_valid_q, mem_wr_q, mem_rd_q,
                                  wb_valid_q, wb_wr_q, wb_rd_q);
            end else begin
                sel_a_d = SEL_RF;
            end
            if (id_use_imm) begin
                sel_b_d = SEL_IMM;
            end else if (id_use_rt) begin
                sel_b_d = fwd_sel(id_rt, ex_valid_q, ex_wr_q, ex_rd_q,
                                  mem_valid_q, mem_wr_q, mem_rd_q,
                                  wb_valid_q, wb_wr_q, wb_rd_q);
            end else begin
                sel_b_d = SEL_RF;
            end
        end
    end

    // Stage records and registered selects.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid_q  <= 1'b0;
            ex_rd_q     <= '0;
            ex_wr_q     <= 1'b0;
            ex_ld_q     <= 1'b0;
            mem_valid_q <= 1'b0;
            mem_rd_q    <= '0;
            mem_wr_q    <= 1'b0;
            wb_valid_q  <= 1'b0;
            wb_rd_q     <= '0;
            wb_wr_q     <= 1'b0;
            sel_a_q     <= SEL_RF;
            sel_b_q     <= SEL_RF;
        end else begin
            ex_valid_q  <= ex_valid_d;
            ex_rd_q     <= ex_rd_d;
            ex_wr_q     <= ex_wr_d;
            ex_ld_q     <= ex_ld_d;
            mem_valid_q <= mem_valid_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            wb_valid_q  <= wb_valid_d;
            wb_rd_q     <= wb_rd_d;
            wb_wr_q     <= wb_wr_d;
            sel_a_q     <= sel_a_d;
            sel_b_q     <= sel_b_d;
        end
    end

    assign ex_sel_a = sel_a_q;
    assign ex_sel_b = sel_b_q;
    assign ex_valid = ex_valid_q;

endmodule

// File: tb/tb_ex_fwd_ctrl.sv
// Directed bench for ex_fwd_ctrl: inputs change 1ns after a rising edge, outputs checked 1ns later.
module tb_ex_fwd_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs, id_rt, id_rd;
    logic       id_use_rs, id_use_rt, id_use_imm, id_reg_write, id_mem_read, id_valid, flush;
    logic       stall, ex_valid;
    logic [2:0] ex_sel_a, ex_sel_b;

    int checks = 0;
    int errors = 0;

    ex_fwd_ctrl #(.REG_W(5), .ZERO_REG(0)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_use_imm(id_use_imm), .id_rd(id_rd), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .id_valid(id_valid), .flush(flush),
        .stall(stall), .ex_sel_a(ex_sel_a), .ex_sel_b(ex_sel_b), .ex_valid(ex_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_ex(input string tag, input logic v, input logic [2:0] a, input logic [2:0] b);
        chk({tag, ".valid"}, {3'b000, ex_valid}, {3'b000, v});
        chk({tag, ".sel_a"}, {1'b0, ex_sel_a}, {1'b0, a});
        chk({tag, ".sel_b"}, {1'b0, ex_sel_b}, {1'b0, b});
    endtask

    task automatic set_id(input logic [4:0] rs, input logic [4:0] rt,
                          input logic urs, input logic urt, input logic imm,
                          input logic [4:0] rd, input logic wr, input logic ld,
                          input logic vld, input logic fl);
        id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt; id_use_imm = imm;
        id_rd = rd; id_reg_write = wr; id_mem_read = ld; id_valid = vld; flush = fl;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic nop();
        set_id(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        nop();
        for (int i = 0; i < 3; i++) step();
    endtask

    initial begin
        rst = 1'b1;
        nop();
        step();
        chk_ex("reset", 1'b0, 3'b000, 3'b000);
        chk("reset.stall", {3'b000, stall}, 4'h0);
        rst = 1'b0;

        // 1: back-to-back dependence
        set_id(5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0);
        step();
        chk_ex("t1.add", 1'b1, 3'b000, 3'b000);
        set_id(5'd3, 5'd4, 1'b1, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0, 1'b1, 1'b0);
        #1 chk("t1.stall", {3'b000, stall}, 4'h0);
        step();
        chk_ex("t1.sub", 1'b1, 3'b001, 3'b000);
        drain();

        // 2: distance 2, distance 3, r0 producer
        set_id(5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0); step();
        set_id(5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0, 1'b1, 1'b0); step();
        set_id(5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b1, 1'b0); step();
        chk_ex("t2.dist2", 1'b1, 3'b010, 3'b000);
        drain();
        set_id(5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0); step();
        set_id(5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0, 1'b1, 1'b0); step();
        set_id(5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0); step();
        set_id(5'd5, 5'd1, 1'b1, 1'b1, 1'b0, 5'd8, 1'b1, 1'b0, 1'b1, 1'b0); step();
        chk_ex("t2.dist3", 1'b1, 3'b011, 3'b000);
        drain();
        set_id(5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0); step();
        set_id(5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 5'd8, 1'b1, 1'b0, 1'b1, 1'b0); step();
        chk_ex("t2.r0", 1'b1, 3'b000, 3'b000);
        drain();

        // 3: two producers of r7, youngest wins
        set_id(5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0); step();
        set_id(5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0); step();
        set_id(5'd7, 5'd7, 1'b1, 1'b1, 1'b0, 5'd8, 1'b1, 1'b0, 1'b1, 1'b0); step();
        chk_ex("t3.double", 1'b1, 3'b001, 3'b001);
        drain();

        // 4: load-use stall then MEM forward; immediate operand avoids the stall
        set_id(5'd1, 5'd2, 1'b1, 1'b0, 1'b1, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0); step();
        set_id(5'd1, 5'd4, 1'b1, 1'b1, 1'b0, 5'd8, 1'b1, 1'b0, 1'b1, 1'b0);
        #1 chk("t4.stall1", {3'b000, stall}, 4'h1);
        step();
        chk_ex("t4.bubble", 1'b0, 3'b000, 3'b000);
        chk("t4.stall2", {3'b000, stall}, 4'h0);
        step();
        chk_ex("t4.fwd", 1'b1, 3'b000, 3'b010);
        drain();
        set_id(5'd1, 5'd2, 1'b1, 1'b0, 1'b1, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0); step();
        set_id(5'd1, 5'd4, 1'b1, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b1, 1'b0);
        #1 chk("t4.imm_stall", {3'b000, stall}, 4'h0);
        step();
        chk_ex("t4.imm", 1'b1, 3'b000, 3'b100);
        drain();

        // 5: flush coincides with load-use; flushed writer of r9 must not forward
        set_id(5'd1, 5'd2, 1'b1, 1'b0, 1'b1, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0); step();
        set_id(5'd1, 5'd4, 1'b1, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0, 1'b1, 1'b1);
        #1 chk("t5.stall", {3'b000, stall}, 4'h0);
        step();
        chk_ex("t5.bubble", 1'b0, 3'b000, 3'b000);
        set_id(5'd9, 5'd4, 1'b1, 1'b1, 1'b0, 5'd8, 1'b1, 1'b0, 1'b1, 1'b0);
        step();
        chk_ex("t5.after", 1'b1, 3'b000, 3'b010);
        drain();

        // 6: async reset with pipeline full of r2 producers and a pending stall
        set_id(5'd1, 5'd3, 1'b1, 1'b1, 1'b0, 5'd2, 1'b1, 1'b0, 1'b1, 1'b0); step();
        set_id(5'd1, 5'd3, 1'b1, 1'b1, 1'b0, 5'd2, 1'b1, 1'b0, 1'b1, 1'b0); step();
        set_id(5'd2, 5'd3, 1'b1, 1'b1, 1'b0, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0); step();
        chk_ex("t6.full", 1'b1, 3'b001, 3'b000);
        set_id(5'd2, 5'd2, 1'b1, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b1, 1'b0);
        #1 chk("t6.prestall", {3'b000, stall}, 4'h1);
        #1 rst = 1'b1;
        #1;
        chk_ex("t6.rst", 1'b0, 3'b000, 3'b000);
        chk("t6.rst_stall", {3'b000, stall}, 4'h0);
        #1 rst = 1'b0;
        step();
        chk_ex("t6.post", 1'b1, 3'b000, 3'b100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
